// File: rtl/mem_bus_arbiter_if.sv
// Shared memory bus between the pipeline arbiter (master) and the memory slave.
// The master drives a registered cycle that is terminated by the slave's ack.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                cyc;
   logic                stb;
   logic                we;
   logic [DATA_W/8-1:0] sel;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W-1:0]   rdata;
   logic                ack;

   modport master (
      output cyc, stb, we, sel, addr, wdata,
      input  rdata, ack
   );

   modport slave (
      input  cyc, stb, we, sel, addr, wdata,
      output rdata, ack
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter for the shared memory bus, data has fixed priority.
// Optional bus watchdog is compiled in with `define ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_done,
   input  logic                mem_req,
   input  logic                mem_we,
   input  logic [DATA_W/8-1:0] mem_sel,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_done,
   input  logic                flush,
   mem_bus_arbiter_if.master   bus,
   output logic                stallreq_if,
   output logic                stallreq_mem,
   output logic                timeout_err
);
   typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM, HOLD} state_t;

   state_t              state, state_next;
   logic                hold_mem, hold_mem_next;
   logic                discard, discard_next;
   logic                discard_eff;
   logic [DATA_W-1:0]   if_rdata_next, mem_rdata_next;
   logic                cyc_next, stb_next, we_next;
   logic [DATA_W/8-1:0] sel_next;
   logic [ADDR_W-1:0]   addr_next;
   logic [DATA_W-1:0]   wdata_next;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] wd_cnt, wd_cnt_next;
   logic             timed_out, timed_out_next;
   logic             wd_expire;

   assign wd_expire = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hold_mem  <= 1'b0;
         discard   <= 1'b0;
         if_rdata  <= '0;
         mem_rdata <= '0;
         bus.cyc   <= 1'b0;
         bus.stb   <= 1'b0;
         bus.we    <= 1'b0;
         bus.sel   <= '0;
         bus.addr  <= '0;
         bus.wdata <= '0;
      end else begin
         state     <= state_next;
         hold_mem  <= hold_mem_next;
         discard   <= discard_next;
         if_rdata  <= if_rdata_next;
         mem_rdata <= mem_rdata_next;
         bus.cyc   <= cyc_next;
         bus.stb   <= stb_next;
         bus.we    <= we_next;
         bus.sel   <= sel_next;
         bus.addr  <= addr_next;
         bus.wdata <= wdata_next;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt    <= '0;
         timed_out <= 1'b0;
      end else begin
         wd_cnt    <= wd_cnt_next;
         timed_out <= timed_out_next;
      end
   end
`endif

   // A flush seen in any BUS_IF cycle, including the ack cycle, discards the fetch.
   assign discard_eff = discard | flush;

   always_comb begin
      state_next     = state;
      hold_mem_next  = hold_mem;
      discard_next   = discard;
      if_rdata_next  = if_rdata;
      mem_rdata_next = mem_rdata;
      cyc_next       = bus.cyc;
      stb_next       = bus.stb;
      we_next        = bus.we;
      sel_next       = bus.sel;
      addr_next      = bus.addr;
      wdata_next     = bus.wdata;
`ifdef ARB_TIMEOUT_EN
      wd_cnt_next    = '0;
      timed_out_next = timed_out;
`endif
      case (state)
         IDLE: begin
            if (mem_req) begin
               state_next    = BUS_MEM;
               hold_mem_next = 1'b1;
               cyc_next      = 1'b1;
               stb_next      = 1'b1;
               we_next       = mem_we;
               sel_next      = mem_sel;
               addr_next     = mem_addr;
               wdata_next    = mem_wdata;
            end else if (if_req && !flush) begin
               state_next    = BUS_IF;
               hold_mem_next = 1'b0;
               cyc_next      = 1'b1;
               stb_next      = 1'b1;
               we_next       = 1'b0;
               sel_next      = '1;
               addr_next     = if_addr;
               wdata_next    = '0;
            end
         end
         BUS_IF: begin
            discard_next = discard_eff;
`ifdef ARB_TIMEOUT_EN
            wd_cnt_next  = wd_cnt + CNT_W'(1);
`endif
            if (bus.ack) begin
               state_next = HOLD;
               cyc_next   = 1'b0;
               stb_next   = 1'b0;
               if (!discard_eff) if_rdata_next = bus.rdata;
`ifdef ARB_TIMEOUT_EN
            end else if (wd_expire) begin
               state_next     = HOLD;
               cyc_next       = 1'b0;
               stb_next       = 1'b0;
               timed_out_next = 1'b1;
               if (!discard_eff) if_rdata_next = '0;
`endif
            end
         end
         BUS_MEM: begin
`ifdef ARB_TIMEOUT_EN
            wd_cnt_next = wd_cnt + CNT_W'(1);
`endif
            if (bus.ack) begin
               state_next = HOLD;
               cyc_next   = 1'b0;
               stb_next   = 1'b0;
               if (!bus.we) mem_rdata_next = bus.rdata;
`ifdef ARB_TIMEOUT_EN
            end else if (wd_expire) begin
               state_next     = HOLD;
               cyc_next       = 1'b0;
               stb_next       = 1'b0;
               timed_out_next = 1'b1;
               mem_rdata_next = '0;
`endif
            end
         end
         HOLD: begin
            state_next   = IDLE;
            discard_next = 1'b0;
`ifdef ARB_TIMEOUT_EN
            timed_out_next = 1'b0;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   assign if_done      = (state == HOLD) && !hold_mem && !discard;
   assign mem_done     = (state == HOLD) && hold_mem;
   assign stallreq_if  = if_req & ~if_done;
   assign stallreq_mem = mem_req & ~mem_done;

`ifdef ARB_TIMEOUT_EN
   assign timeout_err = (state == HOLD) && timed_out;
`else
   assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: scoreboards for bus cycles and done strobes.
// Build with +define+ARB_TIMEOUT_EN to include the watchdog scenario.
module tb_mem_bus_arbiter;
   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_txn_t;

   typedef struct {
      logic [31:0] data;
      logic        tmo;
   } done_txn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, mem_req, mem_we, flush;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [3:0]  mem_sel;
   logic [31:0] if_rdata, mem_rdata;
   logic        if_done, mem_done, stallreq_if, stallreq_mem, timeout_err;

   logic        slave_ack   = 1'b0;
   logic        stray_ack   = 1'b0;
   logic [31:0] slave_rdata = '0;
   bit          slave_on    = 1'b1;
   int          ack_delay   = 0;
   int          cyc_age     = 0;

   int n_checks = 0;
   int n_fail   = 0;

   bus_txn_t  exp_bus[$];
   done_txn_t exp_if[$];
   done_txn_t exp_mem[$];

   mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   assign bus.ack   = slave_ack | stray_ack;
   assign bus.rdata = slave_rdata;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_rdata     (if_rdata),
      .if_done      (if_done),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_sel      (mem_sel),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_done     (mem_done),
      .flush        (flush),
      .bus          (bus.master),
      .stallreq_if  (stallreq_if),
      .stallreq_mem (stallreq_mem),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] slave_word(input logic [31:0] a);
      if (a == 32'h0000_0040) return 32'h2401_0005;
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // which: 0 mem_done, 1 if_done, 2 bus cyc high, 3 bus cyc low
   task automatic wait_for(input int which, input string tag);
      bit hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         case (which)
            0: hit = mem_done;
            1: hit = if_done;
            2: hit = bus.cyc;
            default: hit = !bus.cyc;
         endcase
      end
      check_output({tag, " wait"}, {63'd0, hit}, 64'd1);
   endtask

   task automatic push_read(input logic [31:0] a, input bit is_mem);
      bus_txn_t  b;
      done_txn_t d;
      b.we = 1'b0; b.sel = 4'hF; b.addr = a; b.wdata = '0;
      d.data = slave_word(a); d.tmo = 1'b0;
      exp_bus.push_back(b);
      if (is_mem) exp_mem.push_back(d);
      else        exp_if.push_back(d);
   endtask

   // Slave model: acks ack_delay cycles after cyc rises and checks the cycle against the scoreboard.
   always @(negedge clk) begin
      if (rst || !bus.cyc) begin
         cyc_age   = 0;
         slave_ack = 1'b0;
      end else begin
         cyc_age++;
         slave_rdata = slave_word(bus.addr);
         if (slave_on && cyc_age == ack_delay + 1) begin
            slave_ack = 1'b1;
            if (exp_bus.size() == 0) begin
               check_output("bus unexpected cycle", {63'd0, bus.cyc}, 64'd0);
            end else begin
               bus_txn_t b;
               b = exp_bus.pop_front();
               check_output("bus stb", {63'd0, bus.stb}, 64'd1);
               check_output("bus we", {63'd0, bus.we}, {63'd0, b.we});
               check_output("bus sel", {60'd0, bus.sel}, {60'd0, b.sel});
               check_output("bus addr", {32'd0, bus.addr}, {32'd0, b.addr});
               if (b.we) check_output("bus wdata", {32'd0, bus.wdata}, {32'd0, b.wdata});
            end
         end else begin
            slave_ack = 1'b0;
         end
      end
   end

   // Done monitor: every strobe must match the next scoreboard entry.
   always @(negedge clk) begin
      if (!rst) begin
         if (if_done) begin
            if (exp_if.size() == 0) check_output("if_done unexpected", {63'd0, if_done}, 64'd0);
            else begin
               done_txn_t d;
               d = exp_if.pop_front();
               check_output("if_rdata", {32'd0, if_rdata}, {32'd0, d.data});
               check_output("if timeout_err", {63'd0, timeout_err}, {63'd0, d.tmo});
            end
         end
         if (mem_done) begin
            if (exp_mem.size() == 0) check_output("mem_done unexpected", {63'd0, mem_done}, 64'd0);
            else begin
               done_txn_t d;
               d = exp_mem.pop_front();
               check_output("mem_rdata", {32'd0, mem_rdata}, {32'd0, d.data});
               check_output("mem timeout_err", {63'd0, timeout_err}, {63'd0, d.tmo});
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global time limit");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   initial begin
      rst = 1'b1; flush = 1'b0;
      if_req = 1'b1; if_addr = 32'h3C;
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h200; mem_wdata = '0;
      ack_delay = 0;

      // Reset with both requests pending
      repeat (3) @(negedge clk);
      check_output("rst bus_cyc", {63'd0, bus.cyc}, 64'd0);
      check_output("rst bus_stb", {63'd0, bus.stb}, 64'd0);
      check_output("rst bus_we", {63'd0, bus.we}, 64'd0);
      check_output("rst bus_sel", {60'd0, bus.sel}, 64'd0);
      check_output("rst bus_addr", {32'd0, bus.addr}, 64'd0);
      check_output("rst bus_wdata", {32'd0, bus.wdata}, 64'd0);
      check_output("rst if_rdata", {32'd0, if_rdata}, 64'd0);
      check_output("rst mem_rdata", {32'd0, mem_rdata}, 64'd0);
      check_output("rst dones", {62'd0, if_done, mem_done}, 64'd0);
      check_output("rst timeout_err", {63'd0, timeout_err}, 64'd0);
      check_output("rst stallreqs", {62'd0, stallreq_if, stallreq_mem}, 64'd3);
      push_read(32'h200, 1'b1);
      push_read(32'h3C, 1'b0);
      rst = 1'b0;
      wait_for(0, "first mem_done");
      check_output("stallreq_mem in done", {63'd0, stallreq_mem}, 64'd0);
      mem_req = 1'b0;
      wait_for(1, "first if_done");
      check_output("stallreq_if in done", {63'd0, stallreq_if}, 64'd0);
      if_req = 1'b0;
      repeat (2) @(negedge clk);

      // IF read with a two-cycle wait-state slave
      ack_delay = 2;
      if_addr = 32'h40; if_req = 1'b1;
      push_read(32'h40, 1'b0);
      #1 check_output("stallreq_if on request", {63'd0, stallreq_if}, 64'd1);
      @(negedge clk);
      check_output("if cyc latency", {63'd0, bus.cyc}, 64'd1);
      repeat (2) @(negedge clk);
      check_output("if cyc held", {63'd0, bus.cyc}, 64'd1);
      check_output("if done before ack", {63'd0, if_done}, 64'd0);
      @(negedge clk);
      check_output("if_done 3 after cyc", {63'd0, if_done}, 64'd1);
      check_output("stallreq_if low at done", {63'd0, stallreq_if}, 64'd0);
      check_output("cyc low at done", {63'd0, bus.cyc}, 64'd0);
      if_req = 1'b0;
      repeat (2) @(negedge clk);

      // Simultaneous requests: MEM write wins, IF follows after two idle clocks
      ack_delay = 1;
      begin
         bus_txn_t b; done_txn_t d;
         b.we = 1'b1; b.sel = 4'b0011; b.addr = 32'h100; b.wdata = 32'hDEAD_BEEF;
         exp_bus.push_back(b);
         d.data = slave_word(32'h200); d.tmo = 1'b0;
         exp_mem.push_back(d);
      end
      push_read(32'h80, 1'b0);
      mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
      mem_req = 1'b1; if_addr = 32'h80; if_req = 1'b1;
      wait_for(0, "write mem_done");
      mem_req = 1'b0; mem_we = 1'b0;
      @(negedge clk);
      check_output("gap cyc +1", {63'd0, bus.cyc}, 64'd0);
      @(negedge clk);
      check_output("if cyc +2 after mem_done", {63'd0, bus.cyc}, 64'd1);
      wait_for(1, "queued if_done");
      if_req = 1'b0;
      repeat (2) @(negedge clk);

      // Flush during a fetch: cycle completes, result is discarded, redirected fetch proceeds
      ack_delay = 3;
      begin
         bus_txn_t b;
         b.we = 1'b0; b.sel = 4'hF; b.addr = 32'hC0; b.wdata = '0;
         exp_bus.push_back(b);
      end
      push_read(32'h44, 1'b0);
      if_addr = 32'hC0; if_req = 1'b1;
      wait_for(2, "flush fetch cyc");
      @(negedge clk);
      flush = 1'b1; if_addr = 32'h44;
      @(negedge clk);
      flush = 1'b0;
      wait_for(3, "flush cycle end");
      check_output("discarded if_done", {63'd0, if_done}, 64'd0);
      check_output("discarded if_rdata hold", {32'd0, if_rdata}, {32'd0, slave_word(32'h80)});
      check_output("discarded stallreq_if", {63'd0, stallreq_if}, 64'd1);
      wait_for(1, "refetch if_done");
      if_req = 1'b0;
      repeat (2) @(negedge clk);

      // Stray acks in IDLE and HOLD
      stray_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("stray idle cyc", {63'd0, bus.cyc}, 64'd0);
         check_output("stray idle dones", {62'd0, if_done, mem_done}, 64'd0);
      end
      stray_ack = 1'b0;
      ack_delay = 0;
      mem_addr = 32'h300; mem_sel = 4'hF; mem_req = 1'b1;
      push_read(32'h300, 1'b1);
      wait_for(0, "stray mem_done");
      mem_req = 1'b0; stray_ack = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_output("stray hold cyc", {63'd0, bus.cyc}, 64'd0);
         check_output("stray hold mem_done", {63'd0, mem_done}, 64'd0);
         check_output("stray hold mem_rdata", {32'd0, mem_rdata}, {32'd0, slave_word(32'h300)});
      end
      stray_ack = 1'b0;
      @(negedge clk);

`ifdef ARB_TIMEOUT_EN
      // Watchdog on a silent slave
      begin
         done_txn_t d;
         int hi_cnt;
         d.data = '0; d.tmo = 1'b1;
         exp_mem.push_back(d);
         slave_on = 1'b0;
         mem_addr = 32'h500; mem_req = 1'b1;
         wait_for(2, "timeout cyc");
         hi_cnt = 1;
         for (int i = 0; i < 40 && bus.cyc; i++) begin
            @(negedge clk);
            if (bus.cyc) hi_cnt++;
         end
         check_output("timeout cyc length", 64'(hi_cnt), 64'd16);
         check_output("timeout mem_done", {63'd0, mem_done}, 64'd1);
         check_output("timeout_err", {63'd0, timeout_err}, 64'd1);
         mem_req = 1'b0; slave_on = 1'b1;
         repeat (2) @(negedge clk);
      end
`endif

      // Reset in the middle of a bus cycle
      ack_delay = 5;
      if_addr = 32'h48; if_req = 1'b1;
      wait_for(2, "reset fetch cyc");
      rst = 1'b1; if_req = 1'b0;
      @(negedge clk);
      check_output("mid rst cyc", {63'd0, bus.cyc}, 64'd0);
      check_output("mid rst stb", {63'd0, bus.stb}, 64'd0);
      check_output("mid rst if_done", {63'd0, if_done}, 64'd0);
      check_output("mid rst if_rdata", {32'd0, if_rdata}, 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_output("after rst idle cyc", {63'd0, bus.cyc}, 64'd0);

      check_output("bus scoreboard drained", 64'(exp_bus.size()), 64'd0);
      check_output("if scoreboard drained", 64'(exp_if.size()), 64'd0);
      check_output("mem scoreboard drained", 64'(exp_mem.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates a single shared memory bus between the instruction-fetch stage and the memory-access stage of the five-stage pipeline. Each granted request becomes a registered, ack-terminated bus cycle. The block returns read data and a one-cycle done strobe to the requester. While a request is outstanding it raises a per-requester stall request toward the pipeline stall controller. A discard mechanism drops fetch results when the pipeline flushes.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYC`, 16, bus-cycle watchdog limit in clocks (used only with `ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `if_req`  in  1  fetch request, held until `if_done`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched word, registered
- `if_done`  out  1  one-cycle completion strobe
- `mem_req`  in  1  data request, held until `mem_done`
- `mem_we`  in  1  1 = write
- `mem_sel`  in  DATA_W/8  byte enables
- `mem_addr`  in  ADDR_W  data address
- `mem_wdata`  in  DATA_W  write data
- `mem_rdata`  out  DATA_W  read data, registered
- `mem_done`  out  1  one-cycle completion strobe
- `flush`  in  1  pipeline flush; discards in-flight fetch
- `bus_cyc`, `bus_stb`  out  1  bus cycle/strobe, registered
- `bus_we`  out  1  bus write enable
- `bus_sel`  out  DATA_W/8  bus byte enables
- `bus_addr`  out  ADDR_W  bus address
- `bus_wdata`  out  DATA_W  bus write data
- `bus_rdata`  in  DATA_W  bus read data
- `bus_ack`  in  1  slave acknowledge
- `stallreq_if`  out  1  `if_req & ~if_done`, combinational
- `stallreq_mem`  out  1  `mem_req & ~mem_done`, combinational
- `timeout_err`  out  1  one-cycle watchdog strobe

## Operation
- FSM states: IDLE, BUS_IF, BUS_MEM, HOLD.
- **IDLE**
  - `mem_req` → BUS_MEM. Fixed priority to data.
  - Otherwise `if_req & ~flush` → BUS_IF.
  - Otherwise stay in IDLE.
  - On transition, register `bus_addr`/`we`/`sel`/`wdata` from the winner and set `bus_cyc = bus_stb = 1`.
  - For IF grants, `bus_we = 0` and `bus_sel` = all ones.
- **BUS_IF / BUS_MEM**
  - Hold all bus outputs stable until `bus_ack`.
  - On `bus_ack`: clear `cyc`/`stb`; capture `bus_rdata` into the granted requester's rdata register (MEM reads only; MEM writes leave `mem_rdata` unchanged); go to HOLD.
- **HOLD**
  - Pulse the granted requester's done for exactly this cycle, then → IDLE unconditionally.
  - Minimum spacing between bus cycles is 2 idle bus clocks.
- **Flush**
  - `flush` asserted in any cycle while in BUS_IF sets the discard flag.
  - A bus cycle is never aborted early; it completes on `bus_ack`.
  - With discard set: `if_rdata` is not updated and `if_done` is not pulsed in HOLD. The discard flag clears in HOLD.
  - `flush` has no effect on BUS_MEM.
- `bus_ack` while in IDLE or HOLD is ignored.
- Starvation: IF waits while `mem_req` is held. This is acceptable because a MEM stall also freezes fetch.

## Timing
- Reset values:
  - state = IDLE
  - all `bus_*` outputs = 0
  - `if_rdata = mem_rdata = 0`
  - `if_done = mem_done = timeout_err = 0`
  - discard flag = 0, watchdog counter = 0
- Request sampled in IDLE at cycle t → `bus_cyc = 1` at t+1.
- `bus_ack` at cycle t+k (k ≥ 1) → done = 1 and rdata valid at t+k+1 → IDLE at t+k+2.
- Zero-wait slave (ack at t+1): minimum request-to-done latency is 2 cycles.
- `stallreq_*` is high from the first cycle of request assertion through the cycle before done. It is low in the done cycle.
- Both requests asserted simultaneously in IDLE: MEM is served first. IF is granted in the first IDLE cycle after MEM's HOLD.
- `rst` during a bus cycle: `bus_cyc`/`stb` are 0 in the next cycle, no done is issued, and the discard flag is cleared.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter runs while in BUS_IF/BUS_MEM and resets on entry to either state.
  - If the counter reaches `TIMEOUT_CYC` without `bus_ack`: drop `cyc`/`stb` and go to HOLD.
  - HOLD then pulses the requester's done with rdata forced to 0 and pulses `timeout_err` in the same cycle.
  - A discarded fetch suppresses `if_done` but still pulses `timeout_err`.
- `ARB_TIMEOUT_EN` undefined:
  - No counter logic.
  - The block waits indefinitely for `bus_ack`.
  - `timeout_err` is tied to 0.

## Test plan
- Reset with `if_req = 1` and `mem_req = 1` → all outputs 0 while `rst` is high, except `stallreq_if = stallreq_mem = 1`. First grant after release goes to MEM.
- IF read, address 0x0000_0040, slave acks 2 cycles after `bus_cyc`, `bus_rdata = 0x2401_0005` → `if_done` 3 cycles after `bus_cyc` rises, `if_rdata = 0x2401_0005`, `stallreq_if` drops in the done cycle.
- `if_req` and `mem_req` rise together, MEM write of 0xDEAD_BEEF to 0x100 with `sel = 4'b0011` → bus shows `we = 1`, `sel = 0011`, write data first. IF bus cycle starts 2 cycles after `mem_done`. `mem_rdata` is unchanged.
- `flush` pulsed mid-BUS_IF → bus cycle completes on ack, no `if_done`, `if_rdata` holds its old value, next IF fetch proceeds normally.
- `ARB_TIMEOUT_EN` with `TIMEOUT_CYC = 16`, slave never acks a MEM read → `bus_cyc` low after 16 cycles, then `mem_done = 1`, `timeout_err = 1`, `mem_rdata = 0`.
- Stray `bus_ack` pulses in IDLE and HOLD → no state change and no done strobes.
